regtable_loader: RTL and testbench
==================================

Name: regtable_loader

Overview:
- Builds the camera register table in BRAM from a host byte stream (UART RX), then starts the register-write sequencer.
- Sits directly upstream of the BRAM read port and the sequencer's init_valid/init_ready handshake.
- Table format: 24-bit entries {reg_addr_hi, reg_addr_lo, reg_data}, starting at address 0. An all-zero entry terminates the table.

Parameters:
- RAM_DEPTH, 256: table depth in entries. Write-address width is $clog2(RAM_DEPTH).
- TIMEOUT_CYCLES, 1000000: idle cycles after which a partial entry is discarded (10 ms at 100 MHz).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- byte_valid  input  1  single-cycle strobe; byte_data is valid this cycle
- byte_data  input  8  received byte, MSB-first within each entry
- bram_we  output  1  BRAM write enable
- bram_waddr  output  $clog2(RAM_DEPTH)  BRAM write address
- bram_din  output  24  BRAM write data
- init_valid  output  1  request to the sequencer to run the table
- init_ready  input  1  sequencer idle and accepting a request
- entry_count  output  $clog2(RAM_DEPTH)  number of non-zero entries in the last handed-off table
- table_full  output  1  sticky: last table was auto-terminated at depth
- bytes_dropped  output  1  sticky: a byte arrived while not in COLLECT
- resync  output  1  sticky: a partial entry was discarded on timeout
- state_out  output  2  current state encoding

Behaviour:
- Reset: state=COLLECT; waddr=0; byte_cnt=0; shift register=0; timeout counter=0; all outputs 0. Reset mid-load aborts with no further writes. BRAM contents are left untouched, and no init_valid is issued.
- States:
  - COLLECT=0
  - WRITE=1
  - TERM=2
  - HANDOFF=3
- COLLECT:
  - On byte_valid: shreg <= {shreg[15:0], byte_data}; byte_cnt++. Timeout counter clears.
  - When the third byte is accepted: byte_cnt <= 0; next state WRITE.
  - With byte_cnt!=0 and no byte_valid, the timeout counter increments each cycle. On reaching TIMEOUT_CYCLES: byte_cnt <= 0, counter <= 0, resync <= 1.
  - byte_valid in the cycle the count would hit TIMEOUT_CYCLES: the byte is accepted and no discard happens.
  - The counter is held at 0 while byte_cnt==0.
- WRITE (exactly one cycle): bram_we=1, bram_waddr=waddr, bram_din=shreg.
  - If shreg==0: next state HANDOFF.
  - Otherwise waddr++ and entry counter++.
  - If the address just written was RAM_DEPTH-2: next state TERM and table_full <= 1. Otherwise next state COLLECT.
- TERM (one cycle): bram_we=1, bram_din=0, bram_waddr=RAM_DEPTH-1; next state HANDOFF.
- HANDOFF:
  - init_valid=1 (registered; asserted the first cycle in HANDOFF) until the first cycle with init_ready=1.
  - On that cycle: entry_count <= entry counter; internal entry counter <= 0; waddr <= 0; next state COLLECT.
  - init_valid deasserts the following cycle and is high for exactly one cycle with init_ready high.
- Latency:
  - The BRAM write occurs 1 cycle after the third byte.
  - init_valid rises 2 cycles after the terminator's third byte, or 3 cycles for an auto-terminated table.
- Byte drops:
  - Any byte_valid while in WRITE, TERM or HANDOFF is discarded and sets bytes_dropped.
  - The upstream source must pace bytes (UART bytes are far slower than 3 cycles).
- Sticky flags:
  - table_full, bytes_dropped and resync clear only on rst_in or on the first accepted byte of a new table (waddr==0, byte_cnt==0).
  - A set and a clear in the same cycle: set wins.
- Empty table: a leading 000000 writes 0 at address 0, hands off with entry_count=0. The sequencer returns to idle immediately.
- bram_we is never asserted outside WRITE and TERM. bram_din and bram_waddr are don't-care when bram_we=0.
- Wrap-around: waddr never exceeds RAM_DEPTH-1. At most RAM_DEPTH-1 non-zero entries are stored per table.

Test Plan:
- Bytes 30 08 82 30 08 02 00 00 00, init_ready=1 -> writes 0x300882@0, 0x300802@1, 0x000000@2. init_valid high one cycle; entry_count=2; waddr back to 0.
- Same stream with init_ready held low 50 cycles; byte 0x31 sent during HANDOFF -> no extra BRAM write, bytes_dropped=1. Handshake completes on the first cycle with init_ready=1.
- TIMEOUT_CYCLES=100: send 30 08, idle 100 cycles, then 31 00 10 00 00 00 -> resync=1, 0x310010@0, 0@1, entry_count=1.
- RAM_DEPTH=8: 7 non-zero entries 0x3000_01..0x3000_07 -> entries @0..6, auto 0@7, table_full=1, entry_count=7, init_valid without a sent terminator.
- Assert rst_in after 4 bytes of a table -> all outputs 0, no BRAM write, no init_valid. A following full stream loads from address 0 normally.
- Leading 00 00 00 -> single write 0@0, entry_count=0, init_valid handshake completes.

Source files
------------

// File: rtl/regtable_loader.sv
// Loads the camera register table into BRAM from a UART byte stream
// and hands it to the register-write sequencer.
//
// Ports:
//   clk_in, rst_in       clock, synchronous active-high reset
//   byte_valid/byte_data received byte strobe and data (MSB first)
//   bram_we/waddr/din    BRAM write port (24-bit entries)
//   init_valid/ready     handshake to start the sequencer
//   entry_count          non-zero entries in last handed-off table
//   table_full           sticky: table auto-terminated at depth
//   bytes_dropped        sticky: byte arrived outside COLLECT
//   resync               sticky: partial entry dropped on timeout
//   state_out            current state encoding
module regtable_loader #(
  parameter int RAM_DEPTH      = 256,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int AW = $clog2(RAM_DEPTH),
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          bram_we,
  output logic [AW-1:0] bram_waddr,
  output logic [23:0]   bram_din,
  output logic          init_valid,
  input  logic          init_ready,
  output logic [AW-1:0] entry_count,
  output logic          table_full,
  output logic          bytes_dropped,
  output logic          resync,
  output logic [1:0]    state_out
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    TERM    = 2'd2,
    HANDOFF = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_W = AW'(RAM_DEPTH - 2);
  localparam logic [AW-1:0] TOP_W  = AW'(RAM_DEPTH - 1);
  localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_d;
  logic [23:0]   shreg;
  logic [1:0]    byte_cnt;
  logic [AW-1:0] waddr;
  logic [AW-1:0] ent_cnt;
  logic [TW-1:0] tcnt;
  logic          tbl_start;

  logic accept, tmo, clr;
  logic set_full, set_drop;

  assign accept = (state == COLLECT) && byte_valid;
  assign tmo    = (state == COLLECT) && !byte_valid
                  && (byte_cnt != 2'd0) && (tcnt == TMAX);
  // flags clear only on the first byte after a handoff (or reset)
  assign clr    = accept && tbl_start
                  && (waddr == '0) && (byte_cnt == 2'd0);
  assign set_full = (state == WRITE) && (shreg != 24'd0)
                    && (waddr == LAST_W);
  assign set_drop = byte_valid && (state != COLLECT);

  assign state_out = state;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= COLLECT;
    else        state <= state_d;
  end

  always_comb begin
    state_d    = state;
    bram_we    = 1'b0;
    bram_waddr = waddr;
    bram_din   = shreg;
    init_valid = 1'b0;
    unique case (state)
      COLLECT: begin
        if (accept && byte_cnt == 2'd2)
          state_d = WRITE;
      end
      WRITE: begin
        bram_we = 1'b1;
        if (shreg == 24'd0)       state_d = HANDOFF;
        else if (waddr == LAST_W) state_d = TERM;
        else                      state_d = COLLECT;
      end
      TERM: begin
        bram_we    = 1'b1;
        bram_waddr = TOP_W;
        bram_din   = 24'd0;
        state_d    = HANDOFF;
      end
      HANDOFF: begin
        init_valid = 1'b1;
        if (init_ready) state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shreg         <= '0;
      byte_cnt      <= '0;
      waddr         <= '0;
      ent_cnt       <= '0;
      tcnt          <= '0;
      entry_count   <= '0;
      table_full    <= 1'b0;
      bytes_dropped <= 1'b0;
      resync        <= 1'b0;
      tbl_start     <= 1'b1;
    end else begin
      unique case (state)
        COLLECT: begin
          if (byte_valid) begin
            shreg <= {shreg[15:0], byte_data};
            tcnt  <= '0;
            if (byte_cnt == 2'd2) byte_cnt <= '0;
            else byte_cnt <= byte_cnt + 2'd1;
          end else if (byte_cnt != 2'd0) begin
            if (tcnt == TMAX) begin
              byte_cnt <= '0;
              tcnt     <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end else begin
            tcnt <= '0;
          end
        end
        WRITE: begin
          if (shreg != 24'd0) begin
            waddr   <= waddr + 1'b1;
            ent_cnt <= ent_cnt + 1'b1;
          end
        end
        TERM: ;
        HANDOFF: begin
          if (init_ready) begin
            entry_count <= ent_cnt;
            ent_cnt     <= '0;
            waddr       <= '0;
          end
        end
      endcase

      if (state == HANDOFF && init_ready) tbl_start <= 1'b1;
      else if (accept)                    tbl_start <= 1'b0;

      table_full    <= set_full | (table_full & ~clr);
      bytes_dropped <= set_drop | (bytes_dropped & ~clr);
      resync        <= tmo | (resync & ~clr);
    end
  end

endmodule

// File: tb/tb_regtable_loader.sv
// Randomised scoreboard bench for regtable_loader.
// A byte-level table model predicts BRAM writes and handoffs.
module tb_regtable_loader;

  localparam int DEPTH = 8;
  localparam int TO    = 100;
  localparam int AW    = $clog2(DEPTH);

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          bram_we;
  logic [AW-1:0] bram_waddr;
  logic [23:0]   bram_din;
  logic          init_valid;
  logic          init_ready;
  logic [AW-1:0] entry_count;
  logic          table_full;
  logic          bytes_dropped;
  logic          resync;
  logic [1:0]    state_out;

  regtable_loader #(
    .RAM_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .bram_we(bram_we),
    .bram_waddr(bram_waddr),
    .bram_din(bram_din),
    .init_valid(init_valid),
    .init_ready(init_ready),
    .entry_count(entry_count),
    .table_full(table_full),
    .bytes_dropped(bytes_dropped),
    .resync(resync),
    .state_out(state_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h @cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s @cyc %0d", nm, cyc);
  endtask

  typedef struct {
    int addr;
    int data;
    int cy;
  } wr_t;

  typedef struct {
    int cnt;
    int rise;
  } ho_t;

  wr_t wq[$];
  ho_t hq[$];

  // reference model of the table being built
  logic [7:0] mbuf[$];
  int m_addr, m_cnt, m_idle;
  bit m_full, m_drop, m_rs, m_fresh, m_pend;
  bit rnd;
  logic [23:0] tbl[$];
  int hs_cnt = 0;

  task automatic model_reset();
    mbuf.delete();
    m_addr  = 0;
    m_cnt   = 0;
    m_idle  = 0;
    m_full  = 0;
    m_drop  = 0;
    m_rs    = 0;
    m_fresh = 1;
    m_pend  = 0;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
    if (mbuf.size() != 0) begin
      m_idle += n;
      if (m_idle >= TO) begin
        mbuf.delete();
        m_rs = 1;
      end
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input int c);
    logic [23:0] e;
    wr_t w;
    ho_t h;
    if (m_pend) begin
      m_drop = 1;
      return;
    end
    if (m_fresh && mbuf.size() == 0 && m_addr == 0) begin
      m_full = 0;
      m_drop = 0;
      m_rs   = 0;
    end
    m_fresh = 0;
    m_idle  = 0;
    mbuf.push_back(b);
    if (mbuf.size() == 3) begin
      e = {mbuf[0], mbuf[1], mbuf[2]};
      mbuf.delete();
      w.addr = m_addr;
      w.data = int'(e);
      w.cy   = c + 1;
      wq.push_back(w);
      if (e == 24'd0) begin
        m_pend = 1;
        h.cnt  = m_cnt;
        h.rise = c + 2;
        hq.push_back(h);
      end else begin
        m_cnt++;
        m_addr++;
        if (m_addr == DEPTH - 1) begin
          w.addr = DEPTH - 1;
          w.data = 0;
          w.cy   = c + 2;
          wq.push_back(w);
          m_full = 1;
          m_pend = 1;
          h.cnt  = m_cnt;
          h.rise = c + 3;
          hq.push_back(h);
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_valid = 1'b1;
    byte_data  = b;
    model_byte(b, cyc);
    step();
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
    idle(gap);
  endtask

  function automatic int rgap(input bit allow);
    int r;
    if (!rnd) return 2;
    r = int'($urandom_range(0, 29));
    if (allow && r == 0) return TO - 1;
    if (allow && r == 1) return TO + int'($urandom_range(0, 3));
    return int'($urandom_range(1, 4));
  endfunction

  task automatic send_entry(input logic [23:0] e, input bit last);
    int tries;
    bit ok;
    int g;
    tries = 0;
    do begin
      ok = 1;
      tries++;
      for (int j = 0; j < 3; j++) begin
        g = (j == 2 && last) ? 3 : rgap(tries < 4);
        send_byte(e[23-8*j -: 8], g);
        if (j < 2 && mbuf.size() == 0) begin
          ok = 0;
          break;
        end
      end
    end while (!ok);
  endtask

  task automatic flags_chk(input string tag);
    chk({tag, "_table_full"}, 32'(table_full), 32'(m_full));
    chk({tag, "_bytes_dropped"}, 32'(bytes_dropped), 32'(m_drop));
    chk({tag, "_resync"}, 32'(resync), 32'(m_rs));
  endtask

  task automatic run_table(input int hold,
                           input bit drop,
                           input bit term);
    int tgt;
    int n;
    tgt = hs_cnt + 1;
    n = tbl.size();
    init_ready = (hold == 0);
    for (int i = 0; i < n; i++)
      send_entry(tbl[i], !term && i == n - 1);
    if (term) send_entry(24'd0, 1'b1);
    if (hold > 0) begin
      if (drop) send_byte(8'h31, 2);
      idle(hold);
      init_ready = 1'b1;
    end
    for (int k = 0; k < 200 && hs_cnt < tgt; k++) idle(1);
    chk("handoff_done", 32'(hs_cnt >= tgt), 32'd1);
    m_pend  = 0;
    m_addr  = 0;
    m_cnt   = 0;
    m_fresh = 1;
    idle(2);
    init_ready = 1'b0;
    flags_chk("post");
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_bram_we"}, 32'(bram_we), 32'd0);
    chk({tag, "_waddr"}, 32'(bram_waddr), 32'd0);
    chk({tag, "_din"}, 32'(bram_din), 32'd0);
    chk({tag, "_init_valid"}, 32'(init_valid), 32'd0);
    chk({tag, "_entry_count"}, 32'(entry_count), 32'd0);
    chk({tag, "_state"}, 32'(state_out), 32'd0);
    flags_chk(tag);
  endtask

  // monitor: pops the scoreboard whenever the DUT writes or hands off
  initial begin
    bit prev_iv;
    bit hs_chk;
    int hs_exp;
    prev_iv = 0;
    hs_chk  = 0;
    hs_exp  = 0;
    forever begin
      @(negedge clk_in);
      if (hs_chk) begin
        hs_chk = 0;
        chk("entry_count", 32'(entry_count), 32'(hs_exp));
        chk("init_valid_fall", 32'(init_valid), 32'd0);
      end
      if (bram_we === 1'b1) begin
        if (wq.size() == 0) fail("unexpected_bram_we");
        else begin
          chk("wr_addr", 32'(bram_waddr), 32'(wq[0].addr));
          chk("wr_data", 32'(bram_din), 32'(wq[0].data));
          chk("wr_cycle", 32'(cyc), 32'(wq[0].cy));
          void'(wq.pop_front());
        end
      end
      if (init_valid === 1'b1 && !prev_iv) begin
        if (hq.size() == 0) fail("unexpected_init_valid");
        else chk("iv_rise_cycle", 32'(cyc), 32'(hq[0].rise));
      end
      if (init_valid === 1'b1 && init_ready === 1'b1) begin
        if (hq.size() != 0) begin
          hs_exp = hq[0].cnt;
          void'(hq.pop_front());
          hs_chk = 1;
        end
        hs_cnt++;
      end
      prev_iv = (init_valid === 1'b1);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog @cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hold;
    bit drop;
    rst_in     = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    init_ready = 1'b0;
    rnd        = 0;
    model_reset();
    repeat (3) step();
    rst_in = 1'b0;
    step();
    zero_chk("reset");

    tbl = '{24'h300882, 24'h300802};
    run_table(0, 0, 1);

    tbl = '{24'h300882, 24'h300802};
    run_table(50, 1, 1);

    send_byte(8'h30, 1);
    send_byte(8'h08, TO + 5);
    tbl = '{24'h310010};
    run_table(0, 0, 1);

    tbl = '{24'h300001, 24'h300002, 24'h300003,
            24'h300004, 24'h300005, 24'h300006,
            24'h300007};
    run_table(0, 0, 0);

    send_byte(8'h30, TO - 1);
    send_byte(8'h00, TO - 1);
    send_byte(8'h05, 2);
    tbl.delete();
    run_table(3, 0, 1);

    send_byte(8'h30, 2);
    send_byte(8'h00, 2);
    send_byte(8'h01, 2);
    send_byte(8'h30, 2);
    rst_in = 1'b1;
    model_reset();
    repeat (2) step();
    rst_in = 1'b0;
    step();
    zero_chk("midreset");
    chk("midreset_no_wr", 32'(wq.size()), 32'd0);
    chk("midreset_no_ho", 32'(hq.size()), 32'd0);

    tbl = '{24'h123456, 24'hABCDEF};
    run_table(0, 0, 1);

    tbl.delete();
    run_table(0, 0, 1);

    rnd = 1;
    for (int t = 0; t < 16; t++) begin
      n = int'($urandom_range(0, DEPTH - 1));
      tbl.delete();
      for (int i = 0; i < n; i++)
        tbl.push_back(24'($urandom_range(1, 24'hFFFFFF)));
      hold = ($urandom_range(0, 1) == 0) ? 0
             : int'($urandom_range(1, 20));
      drop = (hold > 0) && ($urandom_range(0, 1) == 1);
      run_table(hold, drop, n < DEPTH - 1);
    end

    idle(4);
    chk("end_wq_empty", 32'(wq.size()), 32'd0);
    chk("end_hq_empty", 32'(hq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
